// File: rtl/stove_pkg.sv
// Shared types and constants for the stove key front end.
// Build option: define KEY_DEBOUNCE_EN to add per-key debounce counters.
package stove_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    localparam int KEY_PWR  = 0;
    localparam int KEY_UP   = 1;
    localparam int KEY_DOWN = 2;
    localparam int KEY_SEL  = 3;

    // 1 ms of stable level at a 50 MHz system clock.
    localparam int DEBOUNCE_CYCLES_50MHZ = 50000;

endpackage

// File: rtl/key_edge_channel.sv
// One key channel: 2-FF synchroniser, optional debounce, rising-edge detect, pending flag.
// Build option: KEY_DEBOUNCE_EN inserts a stable-count filter before the level FF.
module key_edge_channel
    import stove_pkg::*;
`ifdef KEY_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
)
`endif
(
    input  logic clk,
    input  logic async_reset,
    input  logic key,
    input  logic accept,
    output logic pending,
    output logic overflow_req
);

    logic sync_meta;
    logic sync_q;
    logic level;
    logic level_next;
    logic rise;

    // NOTE: sequential state always uses non-blocking assignments so every FF samples pre-edge values.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= key;
            sync_q    <= sync_meta;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Any return to the current level restarts the count.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            count <= '0;
        end else if (sync_q == level) begin
            count <= '0;
        end else if (count == CNT_W'(DEBOUNCE_CYCLES)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign level_next = (sync_q != level && count == CNT_W'(DEBOUNCE_CYCLES)) ? sync_q : level;
`else
    assign level_next = sync_q;
`endif

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            level   <= 1'b0;
            rise    <= 1'b0;
            pending <= 1'b0;
        end else begin
            level   <= level_next;
            rise    <= level_next & ~level;
            pending <= rise | (pending & ~accept);
        end
    end

    // A new edge on an unserved key is coalesced into the existing event.
    assign overflow_req = rise & pending & ~accept;

endmodule

// File: rtl/key_event_scheduler.sv
// Key events -> round-robin arbiter -> valid/ready event port for the stove control FSM.
// Build option: KEY_DEBOUNCE_EN enables DEBOUNCE_CYCLES filtering in every channel.
module key_event_scheduler
    import stove_pkg::*;
#(
    parameter  int N_KEYS          = 4,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    localparam int ID_W            = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              async_reset,
    input  logic [N_KEYS-1:0] key_in,
    input  logic              enable,
    input  logic              evt_ready,
    input  logic              clear_overflow,
    output logic              evt_valid,
    output logic [ID_W-1:0]   evt_id,
    output logic [N_KEYS-1:0] pending,
    output logic              overflow
);

    if (N_KEYS < 2 || N_KEYS > 8) begin : g_bad_n_keys
        $error("key_event_scheduler: N_KEYS must be 2..8");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_event_scheduler: DEBOUNCE_CYCLES must be at least 1");
    end

    state_t              state_q, state_d;
    logic                valid_d;
    logic [ID_W-1:0]     id_d;
    logic [ID_W-1:0]     last_grant, last_d;
    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     cand;
    logic                found;
    logic                accept;
    logic [N_KEYS-1:0]   accept_mask;
    logic [N_KEYS-1:0]   ovf_req;

    assign accept = evt_valid & evt_ready;

    always_comb begin
        accept_mask = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            accept_mask[i] = accept && (evt_id == ID_W'(i));
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
`ifdef KEY_DEBOUNCE_EN
        key_edge_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
`else
        key_edge_channel u_ch (
`endif
            .clk          (clk),
            .async_reset  (async_reset),
            .key          (key_in[i]),
            .accept       (accept_mask[i]),
            .pending      (pending[i]),
            .overflow_req (ovf_req[i])
        );
    end

    // Search upward from the key after the last grant, wrapping, so every key gets a turn.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int off = 1; off <= N_KEYS; off++) begin
            cand = ID_W'((int'(last_grant) + off) % N_KEYS);
            if (!found && pending[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = evt_valid;
        id_d    = evt_id;
        last_d  = last_grant;
        case (state_q)
            ST_IDLE: begin
                if (enable && found) begin
                    valid_d = 1'b1;
                    id_d    = pick;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // The offer stays put until accepted, regardless of enable.
                if (evt_ready) begin
                    valid_d = 1'b0;
                    last_d  = evt_id;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q    <= ST_IDLE;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            last_grant <= ID_W'(N_KEYS - 1);
        end else begin
            state_q    <= state_d;
            evt_valid  <= valid_d;
            evt_id     <= id_d;
            last_grant <= last_d;
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            overflow <= 1'b0;
        end else if (|ovf_req) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
